// File: rtl/tomasulo_rs_mc_pkg.sv
// Shared types and defaults for the Tomasulo reservation station.
package tomasulo_rs_mc_pkg;

  localparam int RS_N_DEFAULT  = 4;
  localparam int CDB_N_DEFAULT = 2;
  localparam int WORD_W        = 32;
  localparam int TAG_W         = 5;
  localparam int ROBID_W       = 5;
  localparam int IMM_W         = 32;
  localparam int WA_W          = 5;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SLL = 4'd5,
    OP_SRL = 4'd6,
    OP_MUL = 4'd7
  } opcode_t;

  // When busy, data[TAG_W-1:0] holds the producer tag being waited on.
  typedef struct packed {
    logic              busy;
    logic [WORD_W-1:0] data;
  } oprand_t;

  typedef struct packed {
    logic               vld;
    opcode_t            op;
    logic [TAG_W-1:0]   tag;
    oprand_t [1:0]      opr;
    logic [ROBID_W-1:0] robid;
    logic [IMM_W-1:0]   imm;
    logic [WA_W-1:0]    wa;
  } rs_entry_t;

endpackage

// File: rtl/tomasulo_rs_mc_if.sv
// Dispatch, CDB snoop and issue bundle of the reservation station.
interface tomasulo_rs_mc_if #(parameter int CDB_N = 2);
  import tomasulo_rs_mc_pkg::*;

  logic                     in_vld;
  logic                     in_rdy;
  opcode_t                  in_op;
  logic [TAG_W-1:0]         in_tag;
  logic [1:0]               in_busy;
  logic [2*WORD_W-1:0]      in_opr;
  logic [ROBID_W-1:0]       in_robid;
  logic [IMM_W-1:0]         in_imm;
  logic [WA_W-1:0]          in_wa;

  logic [CDB_N-1:0]         cdb_vld;
  logic [CDB_N*TAG_W-1:0]   cdb_tag;
  logic [CDB_N*WORD_W-1:0]  cdb_wdata;

  logic                     iss_vld;
  logic                     iss_rdy;
  logic [2*WORD_W-1:0]      iss_rdata;
  opcode_t                  iss_op;
  logic [TAG_W-1:0]         iss_tag;
  logic [ROBID_W-1:0]       iss_robid;
  logic [IMM_W-1:0]         iss_imm;
  logic [WA_W-1:0]          iss_wa;

  modport master (
    output in_vld, in_op, in_tag, in_busy, in_opr, in_robid, in_imm, in_wa,
    output cdb_vld, cdb_tag, cdb_wdata, iss_rdy,
    input  in_rdy, iss_vld, iss_rdata, iss_op, iss_tag, iss_robid, iss_imm, iss_wa
  );

  modport slave (
    input  in_vld, in_op, in_tag, in_busy, in_opr, in_robid, in_imm, in_wa,
    input  cdb_vld, cdb_tag, cdb_wdata, iss_rdy,
    output in_rdy, iss_vld, iss_rdata, iss_op, iss_tag, iss_robid, iss_imm, iss_wa
  );

endinterface

// File: rtl/tomasulo_rs_mc_age_matrix.sv
// Age matrix: tracks relative allocation order and grants the oldest requester.
module tomasulo_rs_mc_age_matrix #(parameter int N = 4) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_alloc,
  input  logic [N-1:0] i_free,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_gnt
);

  // r_older[i][j] = 1 means entry i was allocated before entry j
  logic [N-1:0] r_older [N];

  // Newly allocated entry becomes younger than all others; freed entries drop all relations
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!i_rst_n) begin
          r_older[i][j] <= 1'b0;
        end else if (i_free[i] || i_free[j] || (i == j)) begin
          r_older[i][j] <= 1'b0;
        end else if (i_alloc[j]) begin
          r_older[i][j] <= 1'b1;
        end else if (i_alloc[i]) begin
          r_older[i][j] <= 1'b0;
        end else begin
          r_older[i][j] <= r_older[i][j];
        end
      end
    end
  end

  // A requester wins when no other requester is older than it
  always_comb begin
    o_gnt = '0;
    for (int i = 0; i < N; i++) begin
      o_gnt[i] = i_req[i];
      for (int j = 0; j < N; j++) begin
        if (i_req[j] && r_older[j][i]) begin
          o_gnt[i] = 1'b0;
        end else begin
          o_gnt[i] = o_gnt[i];
        end
      end
    end
  end

endmodule

// File: rtl/tomasulo_rs_mc.sv
// Reservation station: holds dispatched ops, wakes operands from the CDB,
// and issues the oldest fully-ready entry to its functional unit.
module tomasulo_rs_mc
  import tomasulo_rs_mc_pkg::*;
#(
  parameter int RS_N  = RS_N_DEFAULT,
  parameter int CDB_N = CDB_N_DEFAULT
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  tomasulo_rs_mc_if.slave            bus,
  output logic [$clog2(RS_N+1)-1:0]  o_occupancy
);

  localparam int OCC_W = $clog2(RS_N+1);

  rs_entry_t        r_ent [RS_N];
  logic [OCC_W-1:0] r_occ;

  logic [RS_N-1:0]  w_free_oh;
  logic             w_any_free;
  logic [RS_N-1:0]  w_ready;
  logic [RS_N-1:0]  w_gnt;
  logic [RS_N-1:0]  w_alloc_oh;
  logic [RS_N-1:0]  w_free_mask;
  logic             w_alloc;
  logic             w_issue;
  rs_entry_t        w_new;
  rs_entry_t        w_sel;

  // Resolve one operand against the CDB; the lowest matching channel wins.
  function automatic oprand_t snoop(input logic busy, input logic [WORD_W-1:0] word,
                                    input logic [CDB_N-1:0] vld,
                                    input logic [CDB_N*TAG_W-1:0] tags,
                                    input logic [CDB_N*WORD_W-1:0] wdata);
    oprand_t res;
    logic    hit;
    res.busy = busy;
    res.data = word;
    hit      = 1'b0;
    for (int c = 0; c < CDB_N; c++) begin
      if (busy && !hit && vld[c] && (word[TAG_W-1:0] == tags[c*TAG_W +: TAG_W])) begin
        res.busy = 1'b0;
        res.data = wdata[c*WORD_W +: WORD_W];
        hit      = 1'b1;
      end else begin
        hit      = hit;
      end
    end
    return res;
  endfunction

  // Find the lowest free slot and the set of entries with both operands resolved
  always_comb begin
    w_free_oh  = '0;
    w_any_free = 1'b0;
    w_ready    = '0;
    for (int i = 0; i < RS_N; i++) begin
      if (!r_ent[i].vld && !w_any_free) begin
        w_free_oh[i] = 1'b1;
        w_any_free   = 1'b1;
      end else begin
        w_free_oh[i] = 1'b0;
      end
      w_ready[i] = r_ent[i].vld & ~r_ent[i].opr[0].busy & ~r_ent[i].opr[1].busy;
    end
  end

  assign bus.in_rdy  = i_rst_n & w_any_free;
  assign bus.iss_vld = i_rst_n & (|w_ready);
  assign w_alloc     = bus.in_vld & bus.in_rdy & ~i_flush;
  assign w_alloc_oh  = {RS_N{w_alloc}} & w_free_oh;
  assign w_issue     = bus.iss_vld & bus.iss_rdy;
  assign w_free_mask = i_flush ? {RS_N{1'b1}} : ({RS_N{w_issue}} & w_gnt);

  tomasulo_rs_mc_age_matrix #(.N(RS_N)) u_age (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_alloc (w_alloc_oh),
    .i_free  (w_free_mask),
    .i_req   (w_ready),
    .o_gnt   (w_gnt)
  );

  // Build the incoming entry, capturing any operand broadcast in the dispatch cycle
  always_comb begin
    w_new.vld    = 1'b1;
    w_new.op     = bus.in_op;
    w_new.tag    = bus.in_tag;
    w_new.robid  = bus.in_robid;
    w_new.imm    = bus.in_imm;
    w_new.wa     = bus.in_wa;
    w_new.opr[0] = snoop(bus.in_busy[0], bus.in_opr[WORD_W-1:0],
                         bus.cdb_vld, bus.cdb_tag, bus.cdb_wdata);
    w_new.opr[1] = snoop(bus.in_busy[1], bus.in_opr[2*WORD_W-1:WORD_W],
                         bus.cdb_vld, bus.cdb_tag, bus.cdb_wdata);
  end

  // Mux the granted (oldest ready) entry onto the issue bus
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < RS_N; i++) begin
      if (w_gnt[i]) begin
        w_sel = r_ent[i];
      end else begin
        w_sel = w_sel;
      end
    end
    bus.iss_op    = w_sel.op;
    bus.iss_tag   = w_sel.tag;
    bus.iss_robid = w_sel.robid;
    bus.iss_imm   = w_sel.imm;
    bus.iss_wa    = w_sel.wa;
    bus.iss_rdata = {w_sel.opr[1].data, w_sel.opr[0].data};
  end

  // Entry storage: allocate, wake busy operands from the CDB, retire on issue
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < RS_N; i++) begin
      if (!i_rst_n) begin
        r_ent[i] <= '0;
      end else if (i_flush) begin
        r_ent[i].vld <= 1'b0;
      end else if (w_alloc_oh[i]) begin
        r_ent[i] <= w_new;
      end else begin
        r_ent[i].vld <= r_ent[i].vld & ~(w_issue & w_gnt[i]);
        for (int k = 0; k < 2; k++) begin
          r_ent[i].opr[k] <= snoop(r_ent[i].opr[k].busy, r_ent[i].opr[k].data,
                                   bus.cdb_vld, bus.cdb_tag, bus.cdb_wdata);
        end
      end
    end
  end

  // Valid-entry counter: +1 on allocate, -1 on issue, cleared by flush
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_occ <= '0;
    end else if (i_flush) begin
      r_occ <= '0;
    end else begin
      case ({w_alloc, w_issue})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_occupancy = r_occ;

endmodule

// File: tb/tb_tomasulo_rs_mc.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// sequence-number based reference model of the reservation station.
module tb_tomasulo_rs_mc;
  import tomasulo_rs_mc_pkg::*;

  localparam int RS_N  = 4;
  localparam int CDB_N = 2;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [2:0] occ;
  int         n_checks;
  int         n_errors;

  tomasulo_rs_mc_if #(.CDB_N(CDB_N)) bus ();

  tomasulo_rs_mc #(.RS_N(RS_N), .CDB_N(CDB_N)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_flush     (flush),
    .bus         (bus),
    .o_occupancy (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    bit          vld;
    int          seq;
    logic [3:0]  op;
    logic [4:0]  tag;
    bit   [1:0]  busy;
    logic [1:0][31:0] data;
    logic [4:0]  robid;
    logic [31:0] imm;
    logic [4:0]  wa;
  } m_ent_t;

  m_ent_t m [RS_N];
  int     seq_ctr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit cdb_lookup(input logic [4:0] t, output logic [31:0] d);
    d = 32'd0;
    for (int c = 0; c < CDB_N; c++)
      if (bus.cdb_vld[c] && bus.cdb_tag[c*5 +: 5] == t) begin
        d = bus.cdb_wdata[c*32 +: 32];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic int model_free();
    for (int i = 0; i < RS_N; i++) if (!m[i].vld) return i;
    return -1;
  endfunction

  function automatic int model_sel();
    int best;
    best = -1;
    for (int i = 0; i < RS_N; i++)
      if (m[i].vld && m[i].busy == 2'b00 && (best < 0 || m[i].seq < m[best].seq)) best = i;
    return best;
  endfunction

  function automatic int model_count();
    int n;
    n = 0;
    for (int i = 0; i < RS_N; i++) if (m[i].vld) n++;
    return n;
  endfunction

  function automatic void model_step();
    int sel, fr;
    logic [31:0] d;
    if (!rst_n || flush) begin
      for (int i = 0; i < RS_N; i++) m[i].vld = 1'b0;
      return;
    end
    sel = model_sel();
    fr  = model_free();
    for (int i = 0; i < RS_N; i++)
      for (int k = 0; k < 2; k++)
        if (m[i].vld && m[i].busy[k] && cdb_lookup(m[i].data[k][4:0], d)) begin
          m[i].busy[k] = 1'b0;
          m[i].data[k] = d;
        end
    if (sel >= 0 && bus.iss_rdy) m[sel].vld = 1'b0;
    if (bus.in_vld && fr >= 0) begin
      m[fr].vld   = 1'b1;
      m[fr].seq   = seq_ctr++;
      m[fr].op    = bus.in_op;
      m[fr].tag   = bus.in_tag;
      m[fr].robid = bus.in_robid;
      m[fr].imm   = bus.in_imm;
      m[fr].wa    = bus.in_wa;
      for (int k = 0; k < 2; k++) begin
        m[fr].busy[k] = bus.in_busy[k];
        m[fr].data[k] = bus.in_opr[k*32 +: 32];
        if (bus.in_busy[k] && cdb_lookup(bus.in_opr[k*32 +: 5], d)) begin
          m[fr].busy[k] = 1'b0;
          m[fr].data[k] = d;
        end
      end
    end
  endfunction

  // Compare outputs mid-cycle, then advance the model on the clock edge.
  task automatic cycle();
    int sel;
    @(negedge clk);
    sel = model_sel();
    chk("in_rdy", bus.in_rdy, rst_n && (model_free() >= 0));
    chk("iss_vld", bus.iss_vld, rst_n && (sel >= 0));
    chk("occupancy", occ, model_count());
    if (rst_n && sel >= 0) begin
      chk("iss_rdata", bus.iss_rdata, {m[sel].data[1], m[sel].data[0]});
      chk("iss_op", bus.iss_op, m[sel].op);
      chk("iss_tag", bus.iss_tag, m[sel].tag);
      chk("iss_robid", bus.iss_robid, m[sel].robid);
      chk("iss_imm", bus.iss_imm, m[sel].imm);
      chk("iss_wa", bus.iss_wa, m[sel].wa);
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    bus.in_vld  = 1'b0;
    bus.cdb_vld = '0;
    flush       = 1'b0;
  endtask

  task automatic set_disp(input logic [3:0] op, input logic [1:0] busy,
                          input logic [31:0] o1, input logic [31:0] o0, input logic [4:0] robid);
    bus.in_vld   = 1'b1;
    bus.in_op    = opcode_t'(op);
    bus.in_tag   = robid + 5'd16;
    bus.in_busy  = busy;
    bus.in_opr   = {o1, o0};
    bus.in_robid = robid;
    bus.in_imm   = {27'd0, robid} + 32'h100;
    bus.in_wa    = robid + 5'd1;
  endtask

  task automatic set_cdb(input logic [1:0] vld, input logic [4:0] t1, input logic [31:0] d1,
                         input logic [4:0] t0, input logic [31:0] d0);
    bus.cdb_vld   = vld;
    bus.cdb_tag   = {t1, t0};
    bus.cdb_wdata = {d1, d0};
  endtask

  initial begin
    n_checks = 0; n_errors = 0; seq_ctr = 0;
    for (int i = 0; i < RS_N; i++) m[i] = '0;
    rst_n = 1'b0; flush = 1'b0;
    bus.iss_rdy = 1'b0; bus.cdb_tag = '0; bus.cdb_wdata = '0;
    set_disp(4'd0, 2'b00, 32'd0, 32'd0, 5'd0);
    idle();
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();

    // 1: resolved ADD issues next cycle
    set_disp(4'd0, 2'b00, 32'd7, 32'd5, 5'd1);
    cycle();
    idle();
    chk("t1_vld", bus.iss_vld, 1'b1);
    chk("t1_rdata", bus.iss_rdata, {32'd7, 32'd5});
    chk("t1_occ1", occ, 3'd1);
    bus.iss_rdy = 1'b1;
    cycle();
    chk("t1_occ0", occ, 3'd0);
    chk("t1_empty", bus.iss_vld, 1'b0);

    // 2: busy opr0 tag 3 woken on channel 1 two cycles later
    set_disp(4'd1, 2'b01, 32'd9, 32'd3, 5'd2);
    cycle(); idle(); cycle();
    set_cdb(2'b10, 5'd3, 32'h55, 5'd9, 32'h77);
    cycle(); idle();
    chk("t2_vld", bus.iss_vld, 1'b1);
    chk("t2_rdata0", bus.iss_rdata[31:0], 32'h55);
    cycle();

    // 3: both operands woken on different channels in one cycle
    set_disp(4'd2, 2'b11, 32'd4, 32'd2, 5'd3);
    cycle(); idle(); cycle();
    chk("t3_wait", bus.iss_vld, 1'b0);
    set_cdb(2'b11, 5'd4, 32'hB0B0, 5'd2, 32'hA0A0);
    cycle(); idle();
    chk("t3_rdata", bus.iss_rdata, {32'hB0B0, 32'hA0A0});
    cycle();

    // 4: fill all entries, wake 2 and 0, issue follows age
    bus.iss_rdy = 1'b0;
    for (int i = 0; i < RS_N; i++) begin
      set_disp(4'd7, 2'b01, 32'd1, 32'd10 + i, 5'(i));
      cycle();
    end
    idle();
    chk("t4_full", bus.in_rdy, 1'b0);
    chk("t4_occ", occ, 3'd4);
    set_cdb(2'b11, 5'd10, 32'h1000, 5'd12, 32'h1200);
    cycle(); idle();
    chk("t4_first", bus.iss_robid, 5'd0);
    bus.iss_rdy = 1'b1;
    cycle();
    chk("t4_second", bus.iss_robid, 5'd2);
    cycle();
    bus.iss_rdy = 1'b0;

    // 6a: flush with 3 valid entries and a concurrent dispatch
    set_disp(4'd3, 2'b11, 32'd30, 32'd31, 5'd9);
    cycle();
    chk("t6_occ3", occ, 3'd3);
    flush = 1'b1;
    cycle(); idle();
    chk("t6_occ0", occ, 3'd0);
    chk("t6_iss", bus.iss_vld, 1'b0);

    // 5: operand captured from the CDB in its dispatch cycle
    set_disp(4'd4, 2'b10, 32'd6, 32'd8, 5'd5);
    set_cdb(2'b01, 5'd0, 32'd0, 5'd6, 32'h99);
    cycle(); idle();
    chk("t5_vld", bus.iss_vld, 1'b1);
    chk("t5_rdata1", bus.iss_rdata[63:32], 32'h99);
    bus.iss_rdy = 1'b1;
    cycle();

    // 6b: reset while a wakeup is in flight
    set_disp(4'd5, 2'b01, 32'd1, 32'd14, 5'd6);
    cycle();
    set_cdb(2'b01, 5'd0, 32'd0, 5'd14, 32'h44);
    rst_n = 1'b0;
    cycle(); idle();
    chk("t6_rst_occ", occ, 3'd0);
    chk("t6_rst_rdy", bus.in_rdy, 1'b0);
    rst_n = 1'b1;
    cycle();

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      logic [4:0] t0, t1;
      bus.in_vld    = 1'($urandom_range(0, 1));
      bus.in_op     = opcode_t'(4'($urandom_range(0, 7)));
      bus.in_tag    = 5'($urandom);
      bus.in_busy   = 2'($urandom);
      bus.in_opr    = {$urandom, $urandom};
      bus.in_opr[4:0]   = 5'($urandom_range(0, 7));
      bus.in_opr[36:32] = 5'($urandom_range(0, 7));
      bus.in_robid  = 5'($urandom);
      bus.in_imm    = $urandom;
      bus.in_wa     = 5'($urandom);
      t0 = 5'($urandom_range(0, 7));
      t1 = 5'($urandom_range(0, 7));
      bus.cdb_vld   = 2'($urandom);
      if (t1 == t0) bus.cdb_vld[1] = 1'b0;
      bus.cdb_tag   = {t1, t0};
      bus.cdb_wdata = {$urandom, $urandom};
      bus.iss_rdy   = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 40) == 0);
      rst_n         = ($urandom_range(0, 150) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
